// File: rtl/des_round_pipe.sv
// DES round-combine stage: P-permute the S-box output, XOR with L, Feistel swap (round 16
// unswapped), STAGES-deep valid/ready pipeline. Define DES_ROUND_PROTO_ERR_EN for proto_err.
`timescale 1ns/1ps
module des_round_pipe #(
  parameter int unsigned STAGES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        perm_en,
  input  logic        start,
  input  logic [31:0] data_in,
  input  logic [31:0] data_left,
  input  logic [31:0] data_right,
  input  logic        out_ready,
  output logic        in_ready,
  output logic [63:0] data_out,
  output logic        round_done,
  output logic [3:0]  round_num,
  output logic        block_done
`ifdef DES_ROUND_PROTO_ERR_EN
  ,
  output logic        proto_err
`endif
);

  typedef struct packed {
    logic        vld;
    logic [3:0]  tag;
    logic [63:0] dat;
  } stage_t;

  stage_t      pipe_q [STAGES];
  stage_t      pipe_d [STAGES];
  stage_t      head_d;
  logic [3:0]  rcnt_q, rcnt_d, tag_in;
  logic [31:0] p_out, f_val;
  logic        advance, accept;

  // DES P table, table entry n maps to data_in[32-n]
  assign p_out = {data_in[16], data_in[25], data_in[12], data_in[11],
                  data_in[3],  data_in[20], data_in[4],  data_in[15],
                  data_in[31], data_in[17], data_in[9],  data_in[6],
                  data_in[27], data_in[14], data_in[1],  data_in[22],
                  data_in[30], data_in[24], data_in[8],  data_in[18],
                  data_in[0],  data_in[5],  data_in[29], data_in[23],
                  data_in[13], data_in[19], data_in[2],  data_in[26],
                  data_in[10], data_in[21], data_in[28], data_in[7]};
  assign f_val = p_out ^ data_left;

  assign round_done = pipe_q[STAGES-1].vld;
  assign round_num  = pipe_q[STAGES-1].tag;
  assign data_out   = pipe_q[STAGES-1].dat;
  assign block_done = round_done && (round_num == 4'd15);

  // The whole chain moves together; only a held output stalls it.
  assign advance  = !(round_done && !out_ready);
  assign in_ready = advance;
  assign accept   = perm_en && advance;

  always_comb begin
    tag_in     = start ? 4'd0 : rcnt_q;
    rcnt_d     = rcnt_q;
    head_d     = pipe_q[0];
    head_d.vld = 1'b0;
    if (accept) begin
      rcnt_d     = tag_in + 4'd1;
      head_d.vld = 1'b1;
      head_d.tag = tag_in;
      head_d.dat = (tag_in == 4'd15) ? {f_val, data_right} : {data_right, f_val};
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign pipe_d[g] = head_d;
    end else begin : g_shift
      assign pipe_d[g] = pipe_q[g-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_q <= '{default: '0};
      rcnt_q <= 4'd0;
    end else if (advance) begin
      pipe_q <= pipe_d;
      rcnt_q <= rcnt_d;
    end
  end

`ifdef DES_ROUND_PROTO_ERR_EN
  logic proto_err_q;

  // Non-start round with no block open (after reset or after round 16).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      proto_err_q <= 1'b0;
    end else if (accept && !start && (rcnt_q == 4'd0)) begin
      proto_err_q <= 1'b1;
    end
  end

  assign proto_err = proto_err_q;
`endif

endmodule

// File: tb/tb_des_round_pipe.sv
// Self-checking bench for des_round_pipe: STAGES=1,2,3 instances share stimulus and are
// checked against a queue-based round model. Honours DES_ROUND_PROTO_ERR_EN.
`timescale 1ns/1ps
module tb_des_round_pipe;
  localparam int NI = 3;
  localparam int PTAB [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                               2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};

  logic        tb_clk = 1'b0;
  logic        rst, perm_en, start, out_ready;
  logic [31:0] data_in, data_left, data_right;
  logic        in_ready   [NI];
  logic [63:0] data_out   [NI];
  logic        round_done [NI];
  logic [3:0]  round_num  [NI];
  logic        block_done [NI];
`ifdef DES_ROUND_PROTO_ERR_EN
  logic        proto_err  [NI];
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 tb_clk = ~tb_clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    des_round_pipe #(.STAGES(g + 1)) u_dut (
      .clk       (tb_clk),
      .rst       (rst),
      .perm_en   (perm_en),
      .start     (start),
      .data_in   (data_in),
      .data_left (data_left),
      .data_right(data_right),
      .out_ready (out_ready),
      .in_ready  (in_ready[g]),
      .data_out  (data_out[g]),
      .round_done(round_done[g]),
      .round_num (round_num[g]),
      .block_done(block_done[g])
`ifdef DES_ROUND_PROTO_ERR_EN
      ,
      .proto_err (proto_err[g])
`endif
    );
  end

  // Reference model: per instance, a list of in-flight rounds with the number of
  // advancing edges each has seen; a round is presented once that reaches STAGES.
  typedef struct packed {
    logic [63:0] dat;
    logic [3:0]  tag;
    logic [3:0]  age;
  } ent_t;

  ent_t       fifo   [NI][4];
  int         cnt    [NI];
  logic [3:0] rc_m   [NI];
  logic       perr_m [NI];

  function automatic logic [31:0] p_ref(input logic [31:0] x);
    logic [31:0] r = '0;
    for (int i = 0; i < 32; i++) r = {r[30:0], 1'(x >> (32 - PTAB[i]))};
    return r;
  endfunction

  function automatic logic [63:0] next_ref(input logic [3:0] tag, input logic [31:0] din,
                                           input logic [31:0] l, input logic [31:0] r);
    logic [31:0] f = p_ref(din) ^ l;
    return (tag == 4'd15) ? {f, r} : {r, f};
  endfunction

  function automatic logic m_valid(input int i);
    return (cnt[i] > 0) && (int'(fifo[i][0].age) == i + 1);
  endfunction

  function automatic logic m_ready(input int i);
    return !(m_valid(i) && !out_ready);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NI; i++) begin
      cnt[i] = 0;
      rc_m[i] = 4'd0;
      perr_m[i] = 1'b0;
    end
  endtask

  // One clock: sample handshake before the edge, update the model after it.
  task automatic cycle();
    logic adv [NI];
    logic acc [NI];
    ent_t e;
    for (int i = 0; i < NI; i++) begin
      adv[i] = m_ready(i);
      acc[i] = perm_en && adv[i];
    end
    @(posedge tb_clk);
    if (!rst) begin
      for (int i = 0; i < NI; i++) begin
        if (adv[i]) begin
          if (m_valid(i)) begin
            for (int k = 0; k < 3; k++) fifo[i][k] = fifo[i][k+1];
            cnt[i]--;
          end
          for (int k = 0; k < cnt[i]; k++) fifo[i][k].age = fifo[i][k].age + 4'd1;
          if (acc[i]) begin
            e.tag = start ? 4'd0 : rc_m[i];
            if (!start && rc_m[i] == 4'd0) perr_m[i] = 1'b1;
            rc_m[i] = start ? 4'd1 : rc_m[i] + 4'd1;
            e.dat = next_ref(e.tag, data_in, data_left, data_right);
            e.age = 4'd1;
            fifo[i][cnt[i]] = e;
            cnt[i]++;
          end
        end
      end
    end
    #1;
  endtask

  task automatic rand_data();
    data_in = $urandom;
    data_left = $urandom;
    data_right = $urandom;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_model();
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    perm_en = 1'b0; start = 1'b0; out_ready = 1'b1;
    data_in = '0; data_left = '0; data_right = '0;
    rst = 1'b0;
    #2 rst = 1'b1;
    clear_model();
    cycle(); cycle();
    for (int i = 0; i < NI; i++) begin
      n_cmp++;
      if ({data_out[i], round_done[i], round_num[i], block_done[i], in_ready[i]} !==
          {64'h0, 1'b0, 4'h0, 1'b0, 1'b1}) begin
        n_bad++;
        $display("FAIL reset_outs s%0d: out=%h done=%b num=%h bd=%b rdy=%b want 0/0/0/0/1",
                 i + 1, data_out[i], round_done[i], round_num[i], block_done[i], in_ready[i]);
      end
`ifdef DES_ROUND_PROTO_ERR_EN
      n_cmp++;
      if (proto_err[i] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_proto s%0d: got %b want 0", i + 1, proto_err[i]);
      end
`endif
    end
    rst = 1'b0;
    cycle();
    perm_en = 1'b1;
    cycle();
    perm_en = 1'b0;
    n_cmp++;
    if ({round_done[0], data_out[0]} !== {1'b1, 64'h0}) begin
      n_bad++;
      $display("FAIL zero_round s1: done=%b out=%h want 1 0", round_done[0], data_out[0]);
    end
    cycle();
    n_cmp++;
    if ({round_done[0], round_done[1]} !== 2'b01) begin
      n_bad++;
      $display("FAIL latency s1/s2: done=%b%b want 01", round_done[0], round_done[1]);
    end
    cycle();
    n_cmp++;
    if ({round_done[1], round_done[2]} !== 2'b01) begin
      n_bad++;
      $display("FAIL latency s2/s3: done=%b%b want 01", round_done[1], round_done[2]);
    end
    cycle(); cycle();
  endtask

  task automatic test_golden();
    logic [31:0] r2;
    out_ready = 1'b1;
    perm_en = 1'b1; start = 1'b1;
    data_in = 32'hf0f0f0f0; data_left = 32'hf0f0f0f0; data_right = 32'h0;
    cycle();
    n_cmp++;
    if ({round_done[0], round_num[0], data_out[0]} !== {1'b1, 4'd0, 64'h00000000_d7657777}) begin
      n_bad++;
      $display("FAIL golden1 s1: done=%b num=%0d out=%h want 1 0 00000000d7657777",
               round_done[0], round_num[0], data_out[0]);
    end
    r2 = $urandom;
    start = 1'b0;
    data_in = 32'h6e6c696e; data_left = 32'h6a61736f; data_right = r2;
    cycle();
    perm_en = 1'b0;
    n_cmp++;
    if ({round_num[0], data_out[0]} !== {4'd1, r2, 32'h327ec59b}) begin
      n_bad++;
      $display("FAIL golden2 s1: num=%0d out=%h want 1 %h327ec59b", round_num[0], data_out[0], r2);
    end
    repeat (3) cycle();
  endtask

  task automatic test_full_block();
    int seen = 0;
    logic [31:0] r16 = '0;
    out_ready = 1'b1;
    data_in = 32'h6e636573; data_left = 32'h62616c61;
    for (int r = 0; r < 20; r++) begin
      perm_en = (r < 16);
      start = (r == 0);
      data_right = $urandom;
      if (r == 15) r16 = data_right;
      cycle();
      for (int i = 0; i < NI; i++) begin
        n_cmp++;
        if (round_done[i] !== m_valid(i) || in_ready[i] !== m_ready(i) ||
            block_done[i] !== (m_valid(i) && fifo[i][0].tag == 4'd15)) begin
          n_bad++;
          $display("FAIL blk_hs s%0d: done=%b rdy=%b bd=%b want done=%b rdy=%b", i + 1,
                   round_done[i], in_ready[i], block_done[i], m_valid(i), m_ready(i));
        end
        if (m_valid(i)) begin
          n_cmp++;
          if ({round_num[i], data_out[i]} !== {fifo[i][0].tag, fifo[i][0].dat}) begin
            n_bad++;
            $display("FAIL blk_data s%0d: num=%0d out=%h want %0d %h", i + 1, round_num[i],
                     data_out[i], fifo[i][0].tag, fifo[i][0].dat);
          end
        end
      end
      if (round_done[2]) begin
        n_cmp++;
        if (round_num[2] !== 4'(seen) || block_done[2] !== (seen == 15) ||
            ((seen == 15) ? data_out[2] !== {32'ha03ec2fd, r16}
                          : data_out[2][31:0] !== 32'ha03ec2fd)) begin
          n_bad++;
          $display("FAIL blk_const s3: num=%0d bd=%b out=%h want num=%0d f=a03ec2fd",
                   round_num[2], block_done[2], data_out[2], seen);
        end
        seen++;
      end
    end
    n_cmp++;
    if (seen != 16) begin
      n_bad++;
      $display("FAIL blk_count s3: got %0d outputs want 16", seen);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] d;
    logic [3:0] t;
    out_ready = 1'b1;
    for (int n = 0; n < 10 && round_done[1] !== 1'b1; n++) begin
      perm_en = 1'b1; start = (n == 0); rand_data();
      cycle();
    end
    n_cmp++;
    if (round_done[1] !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_first s2: no output within 10 cycles, done=%b", round_done[1]);
    end else begin
      d = data_out[1];
      t = round_num[1];
      out_ready = 1'b0;
      for (int n = 0; n < 5; n++) begin
        perm_en = 1'b1; start = 1'b0; rand_data();
        cycle();
        n_cmp++;
        if ({in_ready[1], round_done[1], round_num[1], data_out[1]} !== {1'b0, 1'b1, t, d}) begin
          n_bad++;
          $display("FAIL bp_hold s2: rdy=%b done=%b num=%0d out=%h want 0 1 %0d %h",
                   in_ready[1], round_done[1], round_num[1], data_out[1], t, d);
        end
      end
    end
    out_ready = 1'b1;
    perm_en = 1'b0;
    for (int n = 0; n < 6; n++) begin
      cycle();
      for (int i = 0; i < NI; i++) begin
        n_cmp++;
        if (round_done[i] !== m_valid(i) || in_ready[i] !== m_ready(i)) begin
          n_bad++;
          $display("FAIL bp_drain_hs s%0d: done=%b rdy=%b want %b %b", i + 1,
                   round_done[i], in_ready[i], m_valid(i), m_ready(i));
        end
        if (m_valid(i)) begin
          n_cmp++;
          if ({round_num[i], data_out[i]} !== {fifo[i][0].tag, fifo[i][0].dat}) begin
            n_bad++;
            $display("FAIL bp_drain s%0d: num=%0d out=%h want %0d %h", i + 1, round_num[i],
                     data_out[i], fifo[i][0].tag, fifo[i][0].dat);
          end
        end
      end
    end
  endtask

  task automatic test_abort();
    out_ready = 1'b1;
    for (int r = 0; r < 7; r++) begin
      perm_en = 1'b1; start = (r == 0 || r == 6); rand_data();
      cycle();
      n_cmp++;
      if ({round_done[0], round_num[0]} !== {1'b1, (r == 6) ? 4'd0 : 4'(r)}) begin
        n_bad++;
        $display("FAIL abort_tag s1 r%0d: done=%b num=%0d", r, round_done[0], round_num[0]);
      end
    end
    start = 1'b0;
    rand_data();
    cycle();
    perm_en = 1'b0;
    rst = 1'b1;
    clear_model();
    #1;
    for (int i = 0; i < NI; i++) begin
      n_cmp++;
      if (round_done[i] !== 1'b0) begin
        n_bad++;
        $display("FAIL async_rst s%0d: done=%b want 0", i + 1, round_done[i]);
      end
    end
    cycle();
    rst = 1'b0;
    for (int n = 0; n < 5; n++) begin
      cycle();
      for (int i = 0; i < NI; i++) begin
        n_cmp++;
        if (round_done[i] !== 1'b0) begin
          n_bad++;
          $display("FAIL rst_drop s%0d: done=%b want 0", i + 1, round_done[i]);
        end
      end
    end
    perm_en = 1'b1; rand_data();
    cycle();
    perm_en = 1'b0;
    n_cmp++;
    if ({round_done[0], round_num[0], data_out[0]} !== {1'b1, 4'd0, fifo[0][0].dat}) begin
      n_bad++;
      $display("FAIL post_rst s1: done=%b num=%0d out=%h want 1 0 %h", round_done[0],
               round_num[0], data_out[0], fifo[0][0].dat);
    end
    repeat (3) cycle();
  endtask

  task automatic test_proto();
    out_ready = 1'b1;
    do_reset();
    perm_en = 1'b1; start = 1'b0; rand_data();
    cycle();
    n_cmp++;
    if ({round_done[0], round_num[0]} !== {1'b1, 4'd0}) begin
      n_bad++;
      $display("FAIL orphan_tag s1: done=%b num=%0d want 1 0", round_done[0], round_num[0]);
    end
    for (int n = 0; n < 4; n++) begin
`ifdef DES_ROUND_PROTO_ERR_EN
      for (int i = 0; i < NI; i++) begin
        n_cmp++;
        if (proto_err[i] !== 1'b1) begin
          n_bad++;
          $display("FAIL proto_sticky s%0d: got %b want 1", i + 1, proto_err[i]);
        end
      end
`endif
      start = (n == 0); rand_data();
      cycle();
    end
    perm_en = 1'b0;
    repeat (4) cycle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      perm_en = ($urandom_range(0, 3) != 0);
      start = ($urandom_range(0, 9) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rand_data();
      cycle();
      for (int i = 0; i < NI; i++) begin
        n_cmp++;
        if (round_done[i] !== m_valid(i) || in_ready[i] !== m_ready(i) ||
            block_done[i] !== (m_valid(i) && fifo[i][0].tag == 4'd15)) begin
          n_bad++;
          $display("FAIL rnd_hs s%0d n%0d: done=%b rdy=%b bd=%b want done=%b rdy=%b", i + 1, n,
                   round_done[i], in_ready[i], block_done[i], m_valid(i), m_ready(i));
        end
        if (m_valid(i)) begin
          n_cmp++;
          if ({round_num[i], data_out[i]} !== {fifo[i][0].tag, fifo[i][0].dat}) begin
            n_bad++;
            $display("FAIL rnd_data s%0d n%0d: num=%0d out=%h want %0d %h", i + 1, n,
                     round_num[i], data_out[i], fifo[i][0].tag, fifo[i][0].dat);
          end
        end
`ifdef DES_ROUND_PROTO_ERR_EN
        n_cmp++;
        if (proto_err[i] !== perr_m[i]) begin
          n_bad++;
          $display("FAIL rnd_proto s%0d n%0d: got %b want %b", i + 1, n, proto_err[i], perr_m[i]);
        end
`endif
      end
    end
  endtask

  initial begin
    test_reset();
    test_golden();
    test_full_block();
    test_backpressure();
    test_abort();
    test_proto();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, %0d compared", n_cmp);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/des_round_pipe.md
# des_round_pipe

Parametrised DES round-combine stage: applies the fixed 32-bit P-permutation to the S-box output, XORs it with the left half and forms the next {L,R} pair with the Feistel swap. It also tracks the 16-round schedule internally, so the last round is emitted unswapped. It sits between the S-box bank and the round-state register of the Triple-DES datapath. It replaces the single-cycle permutation block with a configurable-depth pipeline and a valid/ready handshake.

## Interface
- STAGES, 1, number of pipeline register stages (legal 1..4); 1 gives the legacy one-cycle latency
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- perm_en  in  1  input valid; a round is accepted when perm_en && in_ready
- start  in  1  qualifies perm_en; the accepted round is round 1 of a new block
- data_in  in  32  S-box output, pre-permutation
- data_left  in  32  current left half L(i-1)
- data_right  in  32  current right half R(i-1)
- out_ready  in  1  downstream can take data this cycle
- in_ready  out  1  stage can accept this cycle
- data_out  out  64  next state: {L_i, R_i} for rounds 1-15, {R16, L16} for round 16
- round_done  out  1  data_out valid (output-side valid)
- round_num  out  4  round index of data_out, 0 = round 1 … 15 = round 16
- block_done  out  1  round_done && round_num == 15

## Operation
- f = P(data_in) ^ data_left, where P is the standard DES P table (bit 1 = MSB).
- Rounds 1-15: data_out = {data_right, f}. Round 16: data_out = {f, data_right}, with no swap.
- Round counter rcnt (4 bit) is sampled on acceptance:
  - with start=1 the tag is 0 and rcnt becomes 1;
  - otherwise the tag is rcnt and rcnt increments, wrapping 15→0.
  - A start during any round aborts the current block and restarts at round 1.
- The tag travels with the data through every stage and appears as round_num.
- Pipeline is a shift chain of STAGES registers, each holding {valid, data, tag}.
  - Global advance = !(round_done && !out_ready).
  - in_ready = advance (combinational).
  - While stalled, all stages and rcnt hold, and data_out stays stable.
- perm_en while !in_ready is ignored: no capture, rcnt unchanged.
- Empty stages never block: a bubble is simply shifted.

## Timing
- Reset (async assert, sync to edge on release) sets all stage valids to 0, data and tags to 0, and rcnt to 0.
  - Outputs during reset: data_out=0, round_done=0, round_num=0, block_done=0, in_ready=1.
- Latency: an input accepted at edge k appears with round_done=1 after edge k+STAGES-1 completes, i.e. registered STAGES cycles later.
- Throughput is 1 round/cycle while out_ready=1.
- round_done stays high and data_out stays constant until the cycle with out_ready=1.
- Asserting rst mid-block drops all in-flight rounds. The next accepted round without start is tagged 0.
- Simultaneous accept and output-consume in the same cycle is legal and sustains full rate.

## Configuration
- DES_ROUND_PROTO_ERR_EN defined:
  - adds output proto_err (1 bit, reset 0, sticky until rst);
  - proto_err sets when a round is accepted with start=0 while rcnt==0 (no block in progress, i.e. after reset or after round 16 was accepted).
- Undefined: no proto_err port; such a round is simply processed as round 1 (tag 0).

## Test plan
- Reset/idle, STAGES=1: hold rst, then release.
  - In reset: all outputs 0, in_ready=1.
  - perm_en pulse with zero data → round_done=1 exactly one cycle later, data_out=64'h0, then round_done=0 the next cycle.
- Golden f, STAGES=1:
  - data_in=32'hf0f0f0f0, data_left=32'hf0f0f0f0, data_right=32'h0, start=1 → data_out=64'h00000000_d7657777, round_num=0.
  - data_in=32'h6e6c696e, data_left=32'h6a61736f → low word 32'h327ec59b.
- Full block: start + 16 back-to-back rounds with data_in=32'h636573… (data_in=32'h616e6365? use data_in=32'h6e636573, data_left=32'h62616c61) at STAGES=3.
  - f=32'ha03ec2fd on every round.
  - round_num runs 0..15; block_done is high only on the 16th output.
  - 16th output is {32'ha03ec2fd, data_right} (unswapped).
- Backpressure, STAGES=2: hold out_ready=0 after the first output.
  - in_ready=0, data_out and round_num frozen for 5 cycles, perm_en inputs dropped.
  - Release → remaining outputs appear in order, one per cycle, with no loss or duplication.
- Abort/reset: at round 7, assert start with a new round.
  - Its tag is 0.
  - Separately, assert rst with 2 rounds in flight → no round_done after release.
- DES_ROUND_PROTO_ERR_EN: after reset, accept a round with start=0 → proto_err=1 the next cycle and it remains set; the build without the macro shows tag 0 and no port.
